// File: rtl/cpu_pkg.sv
// Shared LEGv8 CPU types and constants used by the fetch stage, its neighbours and the bench.
package cpu_pkg;

  localparam int INSTR_W = 32;

  // Bubble word injected downstream when no real instruction is available.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503_201F;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_branch_target.sv
// Branch target adder: branch PC plus word offset scaled to bytes, wrapping modulo 2^ADDR_W.
module branch_target #(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [63:0]       br_imm,
  output logic [ADDR_W-1:0] target
);

  logic [63:0] imm_bytes_s;

  assign imm_bytes_s = br_imm << 2;
  assign target      = br_pc + imm_bytes_s[ADDR_W-1:0];

endmodule

// File: rtl/instr_fetch.sv
// LEGv8 fetch stage: owns the PC, fetches over a req/ack memory port and hands {pc, instr}
// to decode; taken branches redirect the PC, and stale in-flight words are dropped.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_pc,
  input  logic [63:0]        br_imm
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  redir_q, redir_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  target_s;
  logic               req_s;

  branch_target #(.ADDR_W(ADDR_W)) u_branch_target (
    .br_pc  (br_pc),
    .br_imm (br_imm),
    .target (target_s)
  );

  // pc_q is the address of the outstanding request; while DISCARD waits out a stale
  // request, the redirect target is parked in redir_q so imem_addr stays stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      redir_q  <= RESET_PC;
      valid_q  <= 1'b0;
      out_pc_q <= {ADDR_W{1'b0}};
      instr_q  <= {INSTR_W{1'b0}};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      redir_q  <= redir_d;
      valid_q  <= valid_d;
      out_pc_q <= out_pc_d;
      instr_q  <= instr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    redir_d  = redir_q;
    valid_d  = valid_q;
    out_pc_d = out_pc_q;
    instr_d  = instr_q;
    req_s    = 1'b0;
    case (state_q)
      FETCH: begin
        req_s = 1'b1;
        if (br_taken) begin
          if (imem_ack) begin
            pc_d = target_s;
          end else begin
            redir_d = target_s;
            state_d = DISCARD;
          end
        end else if (imem_ack) begin
          instr_d  = imem_rdata;
          out_pc_d = pc_q;
          valid_d  = 1'b1;
          state_d  = HOLD;
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        // A redirect flushes the held word even if decode accepts it this cycle.
        if (br_taken) begin
          valid_d = 1'b0;
          pc_d    = target_s;
          state_d = FETCH;
        end else if (out_ready) begin
          valid_d = 1'b0;
          pc_d    = pc_q + ADDR_W'(3'd4);
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      DISCARD: begin
        req_s = 1'b1;
        if (imem_ack) begin
          pc_d    = br_taken ? target_s : redir_q;
          state_d = FETCH;
        end else if (br_taken) begin
          redir_d = target_s;
        end else begin
          state_d = DISCARD;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = FETCH;
      end
    endcase
  end

  // Request drops the moment reset asserts, without waiting for a clock edge.
  assign imem_req  = req_s & reset_n;
  assign imem_addr = pc_q;
  assign out_valid = valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = instr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios then random traffic, all checked
// against a transaction-level model of the fetch rules.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        br_taken;
  logic [63:0] br_pc;
  logic [63:0] br_imm;

  int n_checks = 0;
  int n_errors = 0;

  // Model: a word is either held for decode or a request is outstanding; an outstanding
  // request may be stale, with the redirect target remembered separately.
  logic        m_held;
  logic        m_stale;
  logic [63:0] m_pc;
  logic [63:0] m_redir;
  logic [63:0] m_opc;
  logic [31:0] m_instr;

  instr_fetch #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .br_taken   (br_taken),
    .br_pc      (br_pc),
    .br_imm     (br_imm)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_held  = 1'b0;
    m_stale = 1'b0;
    m_pc    = 64'h0;
    m_redir = 64'h0;
    m_opc   = 64'h0;
    m_instr = 32'h0;
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_req"}, {63'd0, imem_req}, {63'd0, !m_held});
    if (!m_held) check_eq({tag, "_addr"}, imem_addr, m_pc);
    check_eq({tag, "_valid"}, {63'd0, out_valid}, {63'd0, m_held && !m_stale});
    if (m_held) begin
      check_eq({tag, "_pc"}, out_pc, m_opc);
      check_eq({tag, "_instr"}, {32'd0, out_instr}, {32'd0, m_instr});
    end
  endtask

  // One cycle: drive inputs, check outputs against the model, clock, advance the model.
  task automatic step(input string tag, input logic ack, input logic [31:0] rdata,
                      input logic rdy, input logic br, input logic [63:0] bpc,
                      input logic [63:0] bimm);
    logic [63:0] tgt;
    imem_ack   = ack;
    imem_rdata = rdata;
    out_ready  = rdy;
    br_taken   = br;
    br_pc      = bpc;
    br_imm     = bimm;
    #1;
    check_model(tag);
    @(posedge clk);
    tgt = bpc + bimm * 64'd4;
    if (m_held) begin
      if (br) begin
        m_held = 1'b0;
        m_pc   = tgt;
      end else if (rdy) begin
        m_held = 1'b0;
        m_pc   = m_pc + 64'd4;
      end
    end else if (m_stale) begin
      if (ack) begin
        m_stale = 1'b0;
        m_pc    = br ? tgt : m_redir;
      end else if (br) begin
        m_redir = tgt;
      end
    end else if (br) begin
      if (ack) m_pc = tgt;
      else begin
        m_stale = 1'b1;
        m_redir = tgt;
      end
    end else if (ack) begin
      m_held  = 1'b1;
      m_opc   = m_pc;
      m_instr = rdata;
    end
    #1;
    imem_ack = 1'b0;
    br_taken = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [63:0] hold_pc;
    logic [31:0] hold_instr;
    reset_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; out_ready = 1'b0;
    br_taken = 1'b0; br_pc = 64'h0; br_imm = 64'h0;
    model_reset();
    #12;
    check_eq("rst_req", {63'd0, imem_req}, 64'd0);
    check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_pc", out_pc, 64'd0);
    check_eq("rst_instr", {32'd0, out_instr}, 64'd0);
    #4 reset_n = 1'b1;
    @(posedge clk); #1;

    // Three zero-wait words, accepted immediately.
    for (int i = 0; i < 3; i++) begin
      check_eq("t1_addr", imem_addr, 64'(4 * i));
      step("t1_ack", 1'b1, 32'hA000_0000 + 32'(i), 1'b1, 1'b0, 64'h0, 64'h0);
      check_eq("t1_opc", out_pc, 64'(4 * i));
      step("t1_acc", 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 64'h0);
    end
    step("t2_pre", 1'b1, 32'h1111_2222, 1'b1, 1'b0, 64'h0, 64'h0);
    step("t2_pre2", 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 64'h0);

    // Ack delayed five cycles at 0x10.
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_req", {63'd0, imem_req}, 64'd1);
      check_eq("t2_addr", imem_addr, 64'h10);
      step("t2_wait", 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0, 64'h0);
    end
    step("t2_ack", 1'b1, 32'h1234_5678, 1'b0, 1'b0, 64'h0, 64'h0);
    check_eq("t2_instr", {32'd0, out_instr}, 64'h1234_5678);

    // Decode stalls four cycles.
    hold_pc = out_pc; hold_instr = out_instr;
    for (int i = 0; i < 4; i++) begin
      step("t3_stall", 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);
      check_eq("t3_pc", out_pc, hold_pc);
      check_eq("t3_instr", {32'd0, out_instr}, {32'd0, hold_instr});
      check_eq("t3_noreq", {63'd0, imem_req}, 64'd0);
    end
    step("t3_acc", 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 64'h0);
    check_eq("t3_next", imem_addr, 64'h14);

    // Redirect while the 0x14 request is outstanding.
    step("t4_br", 1'b0, 32'h0, 1'b1, 1'b1, 64'h20, 64'hFFFF_FFFF_FFFF_FFFE);
    step("t4_stale", 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, 64'h0, 64'h0);
    check_eq("t4_addr", imem_addr, 64'h18);
    check_eq("t4_novalid", {63'd0, out_valid}, 64'd0);
    step("t4_ack", 1'b1, 32'h0018_0018, 1'b0, 1'b0, 64'h0, 64'h0);
    check_eq("t4_opc", out_pc, 64'h18);

    // Redirect and accept together in HOLD.
    step("t5_br", 1'b0, 32'h0, 1'b1, 1'b1, 64'h8, 64'd3);
    check_eq("t5_valid", {63'd0, out_valid}, 64'd0);
    check_eq("t5_addr", imem_addr, 64'h14);

    // Asynchronous reset mid-fetch.
    step("t6_wait", 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_req", {63'd0, imem_req}, 64'd0);
    check_eq("t6_valid", {63'd0, out_valid}, 64'd0);
    model_reset();
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_restart", imem_addr, 64'h0);

    // Random traffic: ack only while a request is expected, occasional branches.
    for (int c = 0; c < 3000; c++) begin
      logic        a, r, b;
      logic [63:0] bp, bi;
      a  = !m_held && ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 1) == 1);
      b  = ($urandom_range(0, 9) == 0);
      bp = {$urandom, $urandom} & ~64'h3;
      bi = 64'($signed($urandom_range(0, 64)) - 32);
      w  = $urandom;
      step("rnd", a, w, r, b, bp, bi);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
